iter_alu: RTL and testbench

Multi-cycle arithmetic unit downstream of the CPU control unit. It accepts a one-cycle operation request with two operands, computes add, sub, mul or div on unsigned `REG_SIZE`-bit values, and returns a registered result with a one-cycle `alu_done` pulse. The control unit writes that result back to RAM. Multiply and divide run iteratively, one bit per cycle; add and sub complete in one cycle.

---
 rtl/iter_alu.sv | 188 ++++++++++++++++++
 tb/tb_iter_alu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle unsigned add/sub/mul/div unit for the CPU control unit.
// Add, sub and divide-by-zero finish in one cycle. Mul (shift-add) and div
// (restoring) retire one bit per enabled cycle over REG_SIZE cycles.
// Optional build macro: ITER_ALU_FAST_MUL_EN selects a single-cycle multiplier
// and removes the MUL state and its iteration datapath.
// Handshake: a one-cycle alu_req is accepted only in IDLE with en=1; requests
// at other times are dropped. alu_done is high while the FSM is in DONE, and
// the result is consumed on the first enabled edge in that state.
module iter_alu #(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          alu_operation,
    input  logic [REG_SIZE-1:0] alu_op1,
    input  logic [REG_SIZE-1:0] alu_op2,
    input  logic                alu_req,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] alu_res,
    output logic                alu_ovf,
    output logic                alu_busy
);
    localparam int W  = REG_SIZE;
    localparam int CW = $clog2(REG_SIZE);
    localparam logic [CW-1:0] LAST_ITER = CW'(REG_SIZE - 1);

`ifdef ITER_ALU_FAST_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dvd_q, dvd_d;   // dividend, shifted out MSB first; becomes quotient
    logic [W-1:0]  dvs_q, dvs_d;   // divisor
    logic [W-1:0]  rem_q, rem_d;   // partial remainder
    logic [W-1:0]  res_q, res_d;
    logic          ovf_q, ovf_d;

    logic [W:0]    add_sum;
    logic [W:0]    div_trial;
    logic [W-1:0]  div_diff;
    logic          div_ge;

`ifdef ITER_ALU_FAST_MUL_EN
    logic [2*W-1:0] mul_prod;
`else
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;  // high half: partial sum, low half: multiplier
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
`endif

    // Next-state, datapath and result computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        res_d   = res_q;
        ovf_d   = ovf_q;

        add_sum   = {1'b0, alu_op1} + {1'b0, alu_op2};
        div_trial = {rem_q, dvd_q[W-1]};
        div_ge    = (div_trial >= {1'b0, dvs_q});
        // When div_ge holds the difference is below the divisor, so W bits suffice.
        div_diff  = div_trial[W-1:0] - dvs_q;

`ifdef ITER_ALU_FAST_MUL_EN
        mul_prod = {{W{1'b0}}, alu_op1} * {{W{1'b0}}, alu_op2};
`else
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
`endif

        case (state_q)
            S_IDLE: begin
                if (alu_req) begin
                    dvd_d = alu_op1;
                    dvs_d = alu_op2;
                    rem_d = '0;
                    cnt_d = '0;
                    case (alu_operation)
                        2'b00: begin
                            res_d   = add_sum[W-1:0];
                            ovf_d   = add_sum[W];
                            state_d = S_DONE;
                        end
                        2'b01: begin
                            res_d   = alu_op1 - alu_op2;
                            ovf_d   = (alu_op1 < alu_op2);
                            state_d = S_DONE;
                        end
                        2'b10: begin
`ifdef ITER_ALU_FAST_MUL_EN
                            res_d   = mul_prod[W-1:0];
                            ovf_d   = |mul_prod[2*W-1:W];
                            state_d = S_DONE;
`else
                            mcand_d = alu_op1;
                            acc_d   = {{W{1'b0}}, alu_op2};
                            state_d = S_MUL;
`endif
                        end
                        default: begin
                            if (alu_op2 == '0) begin
                                res_d   = '1;
                                ovf_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_DIV;
                            end
                        end
                    endcase
                end
            end
`ifndef ITER_ALU_FAST_MUL_EN
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    res_d   = mul_next[W-1:0];
                    ovf_d   = |mul_next[2*W-1:W];
                    state_d = S_DONE;
                end
            end
`endif
            S_DIV: begin
                rem_d = div_ge ? div_diff : div_trial[W-1:0];
                dvd_d = {dvd_q[W-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    res_d   = {dvd_q[W-2:0], div_ge};
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over the global enable
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
`ifndef ITER_ALU_FAST_MUL_EN
            mcand_q <= '0;
            acc_q   <= '0;
`endif
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
`ifndef ITER_ALU_FAST_MUL_EN
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign alu_done = (state_q == S_DONE);
    assign alu_busy = (state_q != S_IDLE);
    assign alu_res  = res_q;
    assign alu_ovf  = ovf_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vectors for iter_alu with a queue-based scoreboard.
// The driver pushes the expected result, flag and completion cycle on each
// accepted request; the monitor pops on every consumed alu_done.
module tb_iter_alu;
    localparam int W = 8;
`ifdef ITER_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 9;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   alu_operation;
    logic [W-1:0] alu_op1;
    logic [W-1:0] alu_op2;
    logic         alu_req;
    logic         alu_done;
    logic [W-1:0] alu_res;
    logic         alu_ovf;
    logic         alu_busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    iter_alu #(.REG_SIZE(W)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .alu_operation(alu_operation),
        .alu_op1(alu_op1),
        .alu_op2(alu_op2),
        .alu_req(alu_req),
        .alu_done(alu_done),
        .alu_res(alu_res),
        .alu_ovf(alu_ovf),
        .alu_busy(alu_busy)
    );

    // clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: one pop per consumed done (enabled cycle with alu_done high)
    always @(negedge clk) begin
        if (!rst && en && alu_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got res %0d expected no done (cycle %0d)", alu_res, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("res", alu_res, mon_e.res);
                check("ovf", alu_ovf, mon_e.ovf);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // driver: one-cycle request pulse; returns one cycle after the accept cycle
    task automatic pulse_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_operation = op;
        alu_op1       = a;
        alu_op2       = b;
        alu_req       = 1'b1;
        @(posedge clk);
        #1;
        alu_req       = 1'b0;
    endtask

    task automatic issue_nowait(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic o, input int lat);
        exp_t e;
        e.res = r;
        e.ovf = o;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        pulse_req(op, a, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((alu_busy || exp_q.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL timeout: got busy=%0d pending=%0d expected idle", alu_busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic o, input int lat);
        issue_nowait(op, a, b, r, o, lat);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        alu_req = 1'b0;
        alu_operation = 2'b00;
        alu_op1 = '0;
        alu_op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", alu_done, 0);
        check("rst_busy", alu_busy, 0);
        check("rst_res", alu_res, 0);
        check("rst_ovf", alu_ovf, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic vectors: op, a, b, result, ovf, latency
        issue(2'b00, 8'd200, 8'd100, 8'd44,  1'b1, 1);
        issue(2'b00, 8'd255, 8'd1,   8'd0,   1'b1, 1);
        issue(2'b00, 8'd3,   8'd4,   8'd7,   1'b0, 1);
        issue(2'b01, 8'd5,   8'd7,   8'd254, 1'b1, 1);
        issue(2'b01, 8'd9,   8'd4,   8'd5,   1'b0, 1);
        issue(2'b10, 8'd13,  8'd11,  8'd143, 1'b0, MUL_LAT);
        issue(2'b10, 8'd20,  8'd20,  8'd144, 1'b1, MUL_LAT);
        issue(2'b10, 8'd255, 8'd255, 8'd1,   1'b1, MUL_LAT);
        issue(2'b10, 8'd0,   8'd77,  8'd0,   1'b0, MUL_LAT);
        issue(2'b11, 8'd200, 8'd7,   8'd28,  1'b0, 9);
        issue(2'b11, 8'd5,   8'd0,   8'd255, 1'b1, 1);
        issue(2'b11, 8'd3,   8'd9,   8'd0,   1'b0, 9);
        issue(2'b11, 8'd255, 8'd1,   8'd255, 1'b0, 9);
        issue(2'b11, 8'd255, 8'd255, 8'd1,   1'b0, 9);

        // second request during mul is ignored; busy covers T1..T(lat)
        issue_nowait(2'b10, 8'd13, 8'd11, 8'd143, 1'b0, MUL_LAT);
        for (int i = 1; i <= MUL_LAT; i++) begin
            if (i == 3) begin
                alu_operation = 2'b00;
                alu_op1 = 8'd1;
                alu_op2 = 8'd1;
                alu_req = 1'b1;
            end
            if (i == 4) alu_req = 1'b0;
            check("busy_in_op", alu_busy, 1);
            @(posedge clk);
            #1;
        end
        alu_req = 1'b0;
        check("busy_after_op", alu_busy, 0);
        wait_idle();

        // en low for three cycles from T4 of div 200/7 pushes done to T12
        issue_nowait(2'b11, 8'd200, 8'd7, 8'd28, 1'b0, 12);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        wait_idle();

        // en low while in DONE holds alu_done
        issue_nowait(2'b00, 8'd1, 8'd2, 8'd3, 1'b0, 3);
        en = 1'b0;
        check("hold_done_t1", alu_done, 1);
        check("hold_res_t1", alu_res, 3);
        @(posedge clk);
        #1;
        check("hold_done_t2", alu_done, 1);
        check("hold_busy_t2", alu_busy, 1);
        @(posedge clk);
        #1;
        check("hold_done_t3", alu_done, 1);
        en = 1'b1;
        wait_idle();

        // reset at T5 of a divide aborts it
        pulse_req(2'b11, 8'd200, 8'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("busy_before_rst", alu_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_done", alu_done, 0);
        check("abort_busy", alu_busy, 0);
        check("abort_res", alu_res, 0);
        check("abort_ovf", alu_ovf, 0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("abort_still_idle", alu_busy, 0);
        issue(2'b00, 8'd1, 8'd1, 8'd2, 1'b0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
